// File: rtl/ysyx_24090018_imem_responder.sv
// Instruction-memory responder: slave end of the fetch path.
// Accepts word fetch requests, returns the addressed instruction after
// LATENCY cycles on a valid/ready response channel. Backing store is an
// internal word array written through the ld_* side port.
// Optional feature macro: YSYX_24090018_IMEM_RAND_DELAY_EN adds 0..3 extra
// cycles of pseudo-random delay per fetch (8-bit LFSR, seed 8'hA5).
//
// state | meaning
// IDLE  | ready for a fetch request (req_ready=1)
// WAIT  | request latched, counting down the remaining latency
// RESP  | response presented, held until resp_ready
module ysyx_24090018_imem_responder #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH_LOG2 = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                    LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_err,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_idx,
  input  logic [DATA_WIDTH-1:0] ld_data
);

  // counter wide enough for LATENCY plus the largest random extra (3)
  localparam int CW = $clog2(LATENCY + 4) + 1;
  localparam logic [ADDR_WIDTH:0] BASE_EXT = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] SPAN     = (ADDR_WIDTH+1)'(1) << (DEPTH_LOG2 + 2);
  localparam logic [ADDR_WIDTH:0] LIMIT    = BASE_EXT + SPAN;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [CW-1:0]           cnt;
  logic [DATA_WIDTH-1:0]   mem [0:(1<<DEPTH_LOG2)-1];

  logic                    accept;
  logic [1:0]              extra;
  logic [CW-1:0]           delay;
  logic [ADDR_WIDTH-1:0]   s_addr;
  logic [ADDR_WIDTH-1:0]   s_off;
  logic [DEPTH_LOG2-1:0]   s_idx;
  logic                    s_err;
  logic [DATA_WIDTH-1:0]   s_word;

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

`ifdef YSYX_24090018_IMEM_RAND_DELAY_EN
  logic [7:0] lfsr;

  // LFSR x^8+x^6+x^5+x^4+1, stepped once per accepted request
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= 8'hA5;
    end else if (accept) begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign extra = lfsr[1:0];
`else
  assign extra = 2'd0;
`endif

  assign delay = CW'(LATENCY) + CW'(extra);

  // In IDLE the sample happens on the accept edge itself, so use the live address
  assign s_addr = (state == IDLE) ? req_addr : addr_q;
  assign s_off  = s_addr - BASE_ADDR;
  assign s_idx  = DEPTH_LOG2'(s_off >> 2);
  assign s_err  = (s_addr[1:0] != 2'b00) ||
                  ({1'b0, s_addr} < BASE_EXT) ||
                  ({1'b0, s_addr} >= LIMIT);
  // write-first: a load hitting the sampled index in the same cycle wins
  assign s_word = (ld_en && (ld_idx == s_idx)) ? ld_data : mem[s_idx];

  // Side-port loads, active in every state including reset
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_idx] <= ld_data;
    end
  end

  // Fetch FSM with registered response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q <= req_addr;
            if (delay == CW'(1)) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_data  <= s_err ? '0 : s_word;
              resp_err   <= s_err;
            end else begin
              state <= WAIT;
              cnt   <= delay - CW'(2);
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_data  <= s_err ? '0 : s_word;
            resp_err   <= s_err;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24090018_imem_responder.sv
// Bench for ysyx_24090018_imem_responder: two instances (LATENCY=1 and 4)
// sharing clock, reset and load bus. Stimulus pushes expected responses
// into per-instance queues; a negedge monitor pops and checks them.
module tb_ysyx_24090018_imem_responder;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [31:0] req_addr  [2];
  logic        resp_valid[2];
  logic        resp_ready[2];
  logic [31:0] resp_data [2];
  logic        resp_err  [2];
  logic        ld_en = 1'b0;
  logic [9:0]  ld_idx = '0;
  logic [31:0] ld_data = '0;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   lat [2] = '{1, 4};
  logic [7:0] lfsr_m [2];
  exp_t q0[$];
  exp_t q1[$];
  exp_t cur[2];
  logic prev_v[2];

  ysyx_24090018_imem_responder #(.LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_data(resp_data[0]), .resp_err(resp_err[0]),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
  );

  ysyx_24090018_imem_responder #(.LATENCY(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_data(resp_data[1]), .resp_err(resp_err[1]),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: a rising resp_valid starts a new response, later cycles must hold it
  always @(negedge clk) begin
    if (rst) begin
      prev_v[0] = 1'b0;
      prev_v[1] = 1'b0;
    end else begin
      for (int w = 0; w < 2; w++) begin
        if (resp_valid[w] && !prev_v[w]) begin
          if (((w == 0) ? q0.size() : q1.size()) == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_resp dut%0d: got resp_valid=1 expected none (cycle %0d)", w, cyc);
          end else begin
            if (w == 0) cur[0] = q0.pop_front();
            else        cur[1] = q1.pop_front();
            check($sformatf("resp_data dut%0d", w), resp_data[w], cur[w].data);
            check($sformatf("resp_err dut%0d", w), 32'(resp_err[w]), 32'(cur[w].err));
            check($sformatf("resp_cycle dut%0d", w), 32'(cyc), 32'(cur[w].due));
          end
        end else if (resp_valid[w]) begin
          check($sformatf("hold_data dut%0d", w), resp_data[w], cur[w].data);
          check($sformatf("hold_err dut%0d", w), 32'(resp_err[w]), 32'(cur[w].err));
        end
        prev_v[w] = resp_valid[w];
      end
    end
  end

  task automatic load(input logic [9:0] idx, input logic [31:0] data);
    @(negedge clk);
    ld_en   = 1'b1;
    ld_idx  = idx;
    ld_data = data;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  // Issue one fetch; expectation is queued at the accept cycle
  task automatic fetch(input int w, input logic [31:0] addr,
                       input logic [31:0] data, input logic err);
    exp_t e;
    int   extra;
    int   guard;
    @(negedge clk);
    req_valid[w] = 1'b1;
    req_addr[w]  = addr;
    guard = 0;
    while (!req_ready[w] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready[w]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout dut%0d: got req_ready=0 expected 1 within 50 cycles", w);
      req_valid[w] = 1'b0;
    end else begin
      extra = 0;
`ifdef YSYX_24090018_IMEM_RAND_DELAY_EN
      extra = int'(lfsr_m[w][1:0]);
      lfsr_m[w] = {lfsr_m[w][6:0], lfsr_m[w][7] ^ lfsr_m[w][5] ^ lfsr_m[w][4] ^ lfsr_m[w][3]};
`endif
      e.data = data;
      e.err  = err;
      e.due  = cyc + lat[w] + extra;
      if (w == 0) q0.push_back(e);
      else        q1.push_back(e);
      @(posedge clk);
      #1 req_valid[w] = 1'b0;
      req_addr[w] = 32'hXXXX_XXXX;
      @(negedge clk);
      check($sformatf("req_ready_busy dut%0d", w), 32'(req_ready[w]), 32'd0);
    end
  endtask

  initial begin
    int guard;
    for (int w = 0; w < 2; w++) begin
      req_valid[w]  = 1'b0;
      req_addr[w]   = '0;
      resp_ready[w] = 1'b1;
      lfsr_m[w]     = 8'hA5;
    end

    // Loads during reset must land
    load(10'd0,    32'h0000_0413);
    load(10'd1,    32'h0010_0093);
    load(10'd2,    32'h0020_0113);
    load(10'd3,    32'h0030_0193);
    load(10'd1023, 32'hDEAD_BEEF);
    @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      check($sformatf("rst_req_ready dut%0d", w), 32'(req_ready[w]), 32'd0);
      check($sformatf("rst_resp_valid dut%0d", w), 32'(resp_valid[w]), 32'd0);
      check($sformatf("rst_resp_data dut%0d", w), resp_data[w], 32'd0);
      check($sformatf("rst_resp_err dut%0d", w), 32'(resp_err[w]), 32'd0);
    end
    rst = 1'b0;

    // Basic single fetch, LATENCY=1
    fetch(0, 32'h8000_0000, 32'h0000_0413, 1'b0);

    // Sequential fetches, LATENCY=4
    fetch(1, 32'h8000_0000, 32'h0000_0413, 1'b0);
    fetch(1, 32'h8000_0004, 32'h0010_0093, 1'b0);
    fetch(1, 32'h8000_0008, 32'h0020_0113, 1'b0);
    fetch(1, 32'h8000_000C, 32'h0030_0193, 1'b0);

    // Backpressure: hold 5 cycles, load same index meanwhile
    resp_ready[0] = 1'b0;
    fetch(0, 32'h8000_0004, 32'h0010_0093, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid dut0", 32'(resp_valid[0]), 32'd1);
      if (i == 1) begin
        ld_en   = 1'b1;
        ld_idx  = 10'd1;
        ld_data = 32'hFFFF_FFFF;
      end
      @(negedge clk);
      ld_en = 1'b0;
    end
    resp_ready[0] = 1'b1;
    fetch(0, 32'h8000_0004, 32'hFFFF_FFFF, 1'b0);
    load(10'd1, 32'h0010_0093);

    // Error and boundary addresses
    fetch(0, 32'h8000_0002, 32'h0000_0000, 1'b1);
    fetch(0, 32'h7FFF_FFFC, 32'h0000_0000, 1'b1);
    fetch(0, 32'h8000_1000, 32'h0000_0000, 1'b1);
    fetch(0, 32'h8000_0FFC, 32'hDEAD_BEEF, 1'b0);
    fetch(0, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1);

    // Reset while WAIT discards the pending fetch
    repeat (3) @(negedge clk);
    fetch(1, 32'h8000_0008, 32'h0020_0113, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    q0.delete();
    q1.delete();
    lfsr_m[0] = 8'hA5;
    lfsr_m[1] = 8'hA5;
    check("rst_req_ready_mid dut1", 32'(req_ready[1]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("rst_discard dut1", 32'(resp_valid[1]), 32'd0);
      @(negedge clk);
    end
    fetch(1, 32'h8000_000C, 32'h0030_0193, 1'b0);

    // Eight back-to-back fetches on LATENCY=1 (random extra delay when enabled)
    for (int i = 0; i < 8; i++) begin
      case (i % 4)
        0: fetch(0, 32'h8000_0000, 32'h0000_0413, 1'b0);
        1: fetch(0, 32'h8000_0004, 32'h0010_0093, 1'b0);
        2: fetch(0, 32'h8000_0008, 32'h0020_0113, 1'b0);
        default: fetch(0, 32'h8000_000C, 32'h0030_0193, 1'b0);
      endcase
    end

    // Drain
    guard = 0;
    while ((q0.size() != 0 || q1.size() != 0 || resp_valid[0] || resp_valid[1]) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d/%0d pending responses expected 0/0", q0.size(), q1.size());
    end
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
